// File: rtl/mult_accum_pkg.sv
// Shared definitions for the multiply-accumulate block: FSM encoding and
// default widths. The ALU top also uses the state encoding for status logic.
package mult_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ACC_W_DEF    = 16;
    localparam int CNT_W_DEF    = 8;
    localparam int SATURATE_DEF = 1;

endpackage

// File: rtl/mult_accum_sat_adder.sv
// Combinational W-bit + 8-bit unsigned adder with carry-out detection and
// optional clamp to all-ones when the carry fires.
module sat_adder #(
    parameter int W        = 16,
    parameter int SATURATE = 1
) (
    input  logic [W-1:0] a,
    input  logic [7:0]   b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] raw_s;

    // Wide add, carry is the overflow indication; clamp or wrap the result
    always_comb begin
        raw_s = {1'b0, a} + {{(W-7){1'b0}}, b};
        carry = raw_s[W];
        if (raw_s[W] && (SATURATE != 0)) begin
            sum = {W{1'b1}};
        end else begin
            sum = raw_s[W-1:0];
        end
    end

endmodule

// File: rtl/mult_accum.sv
// Accumulates a host-specified number of 8-bit multiplier products into a
// wide register and presents the total with sticky error/overflow flags on a
// valid/ready result port.
module mult_accum
    import mult_accum_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SATURATE = SATURATE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_product,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_err,
    output logic             out_ovf,
    output logic             busy
);

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   rem_r;
    logic               err_r;
    logic               ovf_r;
    logic [ACC_W-1:0]   add_sum_s;
    logic               add_carry_s;

    sat_adder #(
        .W        (ACC_W),
        .SATURATE (SATURATE)
    ) u_add (
        .a     (acc_r),
        .b     (in_product),
        .sum   (add_sum_s),
        .carry (add_carry_s)
    );

    // FSM, product counter, accumulator and sticky flags; abort wins over all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            rem_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (abort) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            rem_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r <= {ACC_W{1'b0}};
                        err_r <= 1'b0;
                        ovf_r <= 1'b0;
                        if (len != {CNT_W{1'b0}}) begin
                            rem_r   <= len;
                            state_r <= ST_RUN;
                        end else begin
                            // empty run: report a zero sum straight away
                            rem_r   <= {CNT_W{1'b0}};
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    // in_ready is high for the whole RUN state
                    if (in_valid) begin
                        acc_r <= add_sum_s;
                        err_r <= err_r | in_err;
                        ovf_r <= ovf_r | add_carry_s;
                        rem_r <= rem_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (rem_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode directly from the state register;
    // result fields are the accumulator and flag registers themselves
    assign in_ready  = (state_r == ST_RUN);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign out_sum   = acc_r;
    assign out_err   = err_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_mult_accum.sv
// Scoreboard bench for mult_accum: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_mult_accum;

    typedef struct packed {
        logic [15:0] sum;
        logic        err;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    // main instance (ACC_W=16, saturating)
    logic        start, abort, in_valid, in_err, out_ready;
    logic [7:0]  len, in_product;
    logic        in_ready, out_valid, out_err, out_ovf, busy;
    logic [15:0] out_sum;
    // shared stimulus for the two 9-bit instances
    logic        s9_start, s9_abort, s9_in_valid, s9_in_err, s9_out_ready;
    logic [7:0]  s9_len, s9_product;
    logic        a_in_ready, a_valid, a_err, a_ovf, a_busy;
    logic [8:0]  a_sum;
    logic        w_in_ready, w_valid, w_err, w_ovf, w_busy;
    logic [8:0]  w_sum;

    int   total = 0;
    int   bad   = 0;
    exp_t qs[3][$];
    logic seen[3];
    exp_t cur[3];

    always #5 clk = ~clk;

    mult_accum #(.ACC_W(16), .CNT_W(8), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .in_err(in_err), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err), .out_ovf(out_ovf), .busy(busy)
    );

    mult_accum #(.ACC_W(9), .CNT_W(8), .SATURATE(1)) dut_sat9 (
        .clk(clk), .rst_n(rst_n), .start(s9_start), .len(s9_len), .abort(s9_abort),
        .in_valid(s9_in_valid), .in_ready(a_in_ready), .in_product(s9_product),
        .in_err(s9_in_err), .out_valid(a_valid), .out_ready(s9_out_ready),
        .out_sum(a_sum), .out_err(a_err), .out_ovf(a_ovf), .busy(a_busy)
    );

    mult_accum #(.ACC_W(9), .CNT_W(8), .SATURATE(0)) dut_wrap9 (
        .clk(clk), .rst_n(rst_n), .start(s9_start), .len(s9_len), .abort(s9_abort),
        .in_valid(s9_in_valid), .in_ready(w_in_ready), .in_product(s9_product),
        .in_err(s9_in_err), .out_valid(w_valid), .out_ready(s9_out_ready),
        .out_sum(w_sum), .out_err(w_err), .out_ovf(w_ovf), .busy(w_busy)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic cmp(input string nm, input logic [15:0] s, input logic e,
                       input logic o, input exp_t x);
        total++;
        if (s !== x.sum || e !== x.err || o !== x.ovf) begin
            bad++;
            $display("FAIL %s: got sum=%0d err=%b ovf=%b, expected sum=%0d err=%b ovf=%b",
                     nm, s, e, o, x.sum, x.err, x.ovf);
        end
    endtask

    task automatic handle(input int k, input logic v, input logic [15:0] s,
                          input logic e, input logic o);
        if (v) begin
            if (!seen[k]) begin
                seen[k] = 1'b1;
                if (qs[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL result%0d unexpected: got sum=%0d, expected no result", k, s);
                    cur[k] = '{sum: s, err: e, ovf: o};
                end else begin
                    cur[k] = qs[k].pop_front();
                    cmp($sformatf("result%0d", k), s, e, o, cur[k]);
                end
            end else begin
                cmp($sformatf("hold%0d", k), s, e, o, cur[k]);
            end
        end else begin
            seen[k] = 1'b0;
        end
    endtask

    // monitor: compare each presented result against the scoreboard
    initial begin
        for (int k = 0; k < 3; k++) seen[k] = 1'b0;
        forever begin
            @(negedge clk);
            handle(0, out_valid, out_sum, out_err, out_ovf);
            handle(1, a_valid, {7'd0, a_sum}, a_err, a_ovf);
            handle(2, w_valid, {7'd0, w_sum}, w_err, w_ovf);
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [15:0] s, input logic e, input logic o);
        qs[0].push_back('{sum: s, err: e, ovf: o});
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_err = 1'b0; out_ready = 1'b1;
        len = 8'd0; in_product = 8'd0;
        s9_start = 1'b0; s9_abort = 1'b0; s9_in_valid = 1'b0; s9_in_err = 1'b0;
        s9_out_ready = 1'b1; s9_len = 8'd0; s9_product = 8'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_sum", out_sum, 16'd0);
        chk("rst_flags", {14'd0, out_err, out_ovf}, 16'd0);
        chk("rst_sum9", {7'd0, a_sum}, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // basic run: 6 + 20 + 255 = 281
        push0(16'd281, 1'b0, 1'b0);
        start = 1'b1; len = 8'd3; tick(); start = 1'b0;
        chk("run_in_ready", {15'd0, in_ready}, 16'd1);
        chk("run_busy", {15'd0, busy}, 16'd1);
        in_valid = 1'b1; in_product = 8'd6;   tick();
        in_product = 8'd20;                    tick();
        in_product = 8'd255;                   tick();
        in_valid = 1'b0;
        chk("latency_valid", {15'd0, out_valid}, 16'd1);
        tick();
        chk("after_hs_valid", {15'd0, out_valid}, 16'd0);

        // gaps, error-flagged product, back-pressure: 5 + 0x90 = 149
        out_ready = 1'b0;
        push0(16'd149, 1'b1, 1'b0);
        start = 1'b1; len = 8'd2; tick(); start = 1'b0;
        in_valid = 1'b1; in_product = 8'd5; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("gap_in_ready", {15'd0, in_ready}, 16'd1);
            tick();
        end
        in_valid = 1'b1; in_product = 8'h90; in_err = 1'b1; tick();
        in_valid = 1'b0; in_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {15'd0, out_valid}, 16'd1);
            tick();
        end
        out_ready = 1'b1; tick();
        chk("stall_release", {15'd0, out_valid}, 16'd0);

        // zero-length run, start ignored during DONE
        out_ready = 1'b0;
        push0(16'd0, 1'b0, 1'b0);
        start = 1'b1; len = 8'd0; tick(); start = 1'b0;
        chk("len0_valid", {15'd0, out_valid}, 16'd1);
        chk("len0_in_ready", {15'd0, in_ready}, 16'd0);
        start = 1'b1; len = 8'd5; tick(); start = 1'b0;
        chk("len0_start_ign", {14'd0, out_valid, in_ready}, 16'd2);
        out_ready = 1'b1; tick();
        chk("len0_idle", {15'd0, busy}, 16'd0);

        // abort mid-run, then fresh run of one product
        start = 1'b1; len = 8'd4; tick(); start = 1'b0;
        in_valid = 1'b1; in_product = 8'd100; tick();
        in_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_sum", out_sum, 16'd0);
        push0(16'd7, 1'b0, 1'b0);
        start = 1'b1; len = 8'd1; tick(); start = 1'b0;
        in_valid = 1'b1; in_product = 8'd7; tick();
        in_valid = 1'b0;
        chk("abort_rerun_valid", {15'd0, out_valid}, 16'd1);
        tick();
        // abort and start together in IDLE
        abort = 1'b1; start = 1'b1; len = 8'd3; tick(); abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", {14'd0, busy, in_ready}, 16'd0);
        tick();
        chk("abort_start_idle", {15'd0, busy}, 16'd0);

        // asynchronous reset between edges mid-run
        start = 1'b1; len = 8'd3; tick(); start = 1'b0;
        in_valid = 1'b1; in_product = 8'd50; tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctl", {13'd0, in_ready, out_valid, busy}, 16'd0);
        chk("arst_sum", out_sum, 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        push0(16'd9, 1'b1, 1'b0);
        start = 1'b1; len = 8'd1; tick(); start = 1'b0;
        in_valid = 1'b1; in_product = 8'd9; in_err = 1'b1; tick();
        in_valid = 1'b0; in_err = 1'b0;
        chk("arst_rerun_sum", out_sum, 16'd9);
        tick();

        // 9-bit accumulator overflow: 255 + 255 + 10 = 520
        qs[1].push_back('{sum: 16'd511, err: 1'b0, ovf: 1'b1});
        qs[2].push_back('{sum: 16'd8,   err: 1'b0, ovf: 1'b1});
        s9_start = 1'b1; s9_len = 8'd3; tick(); s9_start = 1'b0;
        s9_in_valid = 1'b1; s9_product = 8'd255; tick();
        tick();
        s9_product = 8'd10; tick();
        s9_in_valid = 1'b0;
        chk("ovf9_valid", {14'd0, a_valid, w_valid}, 16'd3);
        tick();
        chk("ovf9_idle", {14'd0, a_busy, w_busy}, 16'd0);

        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("queue%0d_empty", k), 16'(qs[k].size()), 16'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_accum.md
Name: mult_accum

Overview:
Downstream consumer of the 8-bit combinational multiplier in the ALU. It takes a sequence of 8-bit products and their overflow/error flags, and sums a host-specified number of them into a wide accumulator. The total is presented on a valid/ready result port. The sum is tagged with a sticky "any product overflowed" flag and an "accumulator overflowed" flag. Typical use is dot products and repeated multiply-add in the ALU datapath.

Parameters:
ACC_W, 16, accumulator and result width in bits; must be >= 9.
CNT_W, 8, width of the length field; maximum run length is 2^CNT_W-1 products.
SATURATE, 1, 1 = clamp accumulator to all-ones on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a run; sampled only in IDLE.
len  input  CNT_W  number of products in the run; sampled with start.
abort  input  1  synchronous cancel; returns to IDLE from any state.
in_valid  input  1  product available from multiplier stage.
in_ready  output  1  block accepts a product this cycle.
in_product  input  8  multiplier result (low 8 bits of product).
in_err  input  1  multiplier overflow flag for in_product.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
out_sum  output  ACC_W  accumulated total.
out_err  output  1  OR of in_err over all accepted products of the run.
out_ovf  output  1  accumulator overflowed at least once during the run.
busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; acc=0; remaining=0; err=0; ovf=0. All outputs are 0: in_ready, out_valid, out_sum, out_err, out_ovf, busy.
- FSM states: IDLE, RUN, DONE. A reset mid-run discards everything.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - start=1 and len!=0: acc, err and ovf clear to 0; remaining<=len; next state RUN.
  - start=1 and len==0: acc, err and ovf clear to 0; next state DONE, reporting sum 0.
- RUN:
  - in_ready=1, combinational from state only; it never depends on in_valid.
  - On an accept (in_valid & in_ready), in the same edge:
    - acc <= acc + zero-extended in_product.
    - err <= err | in_err.
    - remaining <= remaining-1.
  - Products flagged in_err are still added; only their truncated low 8 bits are used.
  - When remaining==1 on an accept, next state is DONE.
  - Without in_valid, state and registers hold indefinitely.
- Overflow:
  - Detected on the carry out of the ACC_W-bit add.
  - Sets ovf sticky.
  - SATURATE=1: acc becomes all ones and stays there, since later adds re-saturate.
  - SATURATE=0: acc keeps the low ACC_W bits.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - out_sum=acc, out_err=err, out_ovf=ovf; all stable until the handshake.
  - out_valid & out_ready: next state IDLE. out_sum, out_err and out_ovf keep their last values in IDLE, but are not meaningful while out_valid=0.
- Latency: out_valid rises on the first clock edge after the final product is accepted. The earliest next start is the cycle after the out handshake, so one IDLE cycle separates runs.
- start outside IDLE is ignored; len is not re-sampled.
- abort=1 in any state: next state IDLE; acc, err, ovf and remaining clear. abort takes priority over start, over an accept, and over the output handshake in the same cycle. An aborted run's accept in that same cycle is discarded.
- Arithmetic is unsigned throughout.

Decomposition:
- Shared package (mult_accum_pkg): FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default width constants. The ALU top reuses these for its status logic.
- One natural sub-module, sat_adder:
  - Parameters: W, SATURATE.
  - Inputs: W-bit a, 8-bit b.
  - Outputs: W-bit sum, 1-bit carry/overflow.
  - Purely combinational.
- The FSM, counter and flag registers live in mult_accum.

Test Plan:
- Reset, then start with len=3; feed products 6, 20, 255 on consecutive cycles -> out_valid one cycle after the 3rd accept; out_sum=281, out_err=0, out_ovf=0.
- start with len=2; in_valid gaps of 4 cycles; the 2nd product has in_err=1 (product 0x90) -> in_ready held high through the gaps; out_err=1; sum includes 0x90; out_valid persists across 5 cycles of out_ready=0 with stable values.
- ACC_W=9: len=3, products 255, 255, 10:
  - SATURATE=1 -> out_sum=511, out_ovf=1.
  - SATURATE=0 -> out_sum=8, out_ovf=1.
- start with len=0 -> DONE next cycle with out_sum=0; in_ready never asserted; start pulsed during DONE is ignored.
- abort during RUN after 1 of 4 products, then a fresh start len=1 with product 7 -> out_sum=7, flags 0. Repeat with abort and start asserted in the same IDLE cycle -> stays IDLE.
- Assert rst_n low mid-RUN, between clock edges -> all outputs 0 immediately; the next run behaves as if from a fresh reset.
